// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives the PC counter, issues single outstanding
// memory reads and buffers tagged instruction words for decode.
module fetch_sequencer #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_value,
    output logic          pc_load,
    output logic          pc_increment,
    output logic [AW-1:0] pc_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_addr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          discard, discard_next;
    logic [AW-1:0] tag;
    logic          grant;
    logic          push;
    logic          pop;
    logic          space;

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign space       = (count < CW'(DEPTH));
    assign instr_valid = (count != CW'(0));
    assign instr_data  = data_q[rd_ptr];
    assign instr_addr  = addr_q[rd_ptr];
    assign pop         = instr_valid && instr_ready && !redirect;

    // State, discard flag and grant tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            discard <= 1'b0;
            tag     <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (grant) begin
                tag <= pc_value;
            end
        end
    end

    // Next-state, counter strobes and memory request
    always_comb begin
        state_next   = state;
        discard_next = discard;
        pc_load      = 1'b0;
        pc_increment = 1'b0;
        pc_data      = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        grant        = 1'b0;
        push         = 1'b0;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                mem_addr = pc_value;
                mem_req  = space && !redirect;
                if (mem_req && mem_gnt) begin
                    pc_increment = 1'b1;
                    grant        = 1'b1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (discard) begin
                        discard_next = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect overrides everything else; a response still owed becomes stale
        if (redirect) begin
            pc_load = 1'b1;
            pc_data = redirect_addr;
            push    = 1'b0;
            if (state == WAIT && !mem_rvalid) begin
                discard_next = 1'b1;
                state_next   = WAIT;
            end else begin
                discard_next = 1'b0;
                state_next   = REQ;
            end
        end
    end

    // Instruction FIFO; redirect flushes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= mem_rdata;
                addr_q[wr_ptr] <= tag;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models the PC counter and a simple
// instruction memory that answers on the cycle after each grant.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_value;
    logic        pc_load;
    logic        pc_increment;
    logic [15:0] pc_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_addr;

    int checks = 0;
    int passed = 0;
    int inc_count = 0;
    logic        auto_mem = 1'b0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;

    fetch_sequencer #(.AW(16), .DW(16), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_value      (pc_value),
        .pc_load       (pc_load),
        .pc_increment  (pc_increment),
        .pc_data       (pc_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr)
    );

    always #5 clk = ~clk;

    // Advance one clock; update the counter model and the memory model
    task automatic tick();
        logic        ld, inc, g, rv;
        logic [15:0] d, ga;
        ld = pc_load; inc = pc_increment; d = pc_data;
        g = mem_req && mem_gnt; ga = mem_addr; rv = mem_rvalid;
        if (inc) inc_count++;
        @(posedge clk);
        #1;
        if (ld) pc_value = d;
        else if (inc) pc_value = pc_value + 16'd1;
        if (rv) pend = 1'b0;
        if (g) begin
            pend = 1'b1;
            pend_addr = ga;
        end
        if (auto_mem) begin
            mem_rvalid = pend;
            mem_rdata  = 16'hA000 + pend_addr;
        end
    endtask

    task automatic do_reset(input logic [15:0] start_pc);
        reset = 1'b1;
        auto_mem = 1'b0; pend = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        redirect = 1'b0; redirect_addr = 16'h0000; instr_ready = 1'b0;
        pc_value = start_pc;
        inc_count = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_value = 16'h1234; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
        redirect = 1'b0; redirect_addr = 16'h0077; instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (pc_load !== 1'b0) $display("FAIL reset_pc_load got %b want 0", pc_load); else passed++;
        checks++; if (pc_increment !== 1'b0) $display("FAIL reset_pc_increment got %b want 0", pc_increment); else passed++;
        checks++; if (pc_data !== 16'h0000) $display("FAIL reset_pc_data got %h want 0000", pc_data); else passed++;
        checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else passed++;
        checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else passed++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid got %b want 0", instr_valid); else passed++;
        checks++; if (instr_data !== 16'h0000) $display("FAIL reset_instr_data got %h want 0000", instr_data); else passed++;
        checks++; if (instr_addr !== 16'h0000) $display("FAIL reset_instr_addr got %h want 0000", instr_addr); else passed++;
    endtask

    task automatic test_stream();
        logic [15:0] exp_d [3] = '{16'hA000, 16'hA001, 16'hA002};
        int          exp_c [3] = '{3, 5, 7};
        int k = 0;
        int grants = 0;
        do_reset(16'h0000);
        mem_gnt = 1'b1; instr_ready = 1'b1; auto_mem = 1'b1;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                checks++; if (instr_data !== exp_d[k]) $display("FAIL stream_data%0d got %h want %h", k, instr_data, exp_d[k]); else passed++;
                checks++; if (instr_addr !== 16'(k)) $display("FAIL stream_addr%0d got %h want %h", k, instr_addr, 16'(k)); else passed++;
                checks++; if (c !== exp_c[k]) $display("FAIL stream_cycle%0d got %0d want %0d", k, c, exp_c[k]); else passed++;
                k++;
            end
            if (mem_req && mem_gnt) grants++;
            tick();
        end
        checks++; if (k !== 3) $display("FAIL stream_words got %0d want 3", k); else passed++;
        checks++; if (inc_count !== grants || grants !== 4) $display("FAIL stream_increments got %0d/%0d want 4/4", inc_count, grants); else passed++;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d [3] = '{16'hA000, 16'hA001, 16'hA002};
        int grants = 0;
        int stuck = 0;
        int unstable = 0;
        int k = 0;
        do_reset(16'h0000);
        mem_gnt = 1'b1; instr_ready = 1'b0; auto_mem = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req && mem_gnt) grants++;
            if (c >= 5 && mem_req) stuck++;
            if (c >= 3 && (!instr_valid || instr_data !== 16'hA000 || instr_addr !== 16'h0000)) unstable++;
            tick();
        end
        checks++; if (grants !== 2) $display("FAIL bp_fill got %0d want 2", grants); else passed++;
        checks++; if (stuck !== 0) $display("FAIL bp_req_when_full got %0d want 0", stuck); else passed++;
        checks++; if (unstable !== 0) $display("FAIL bp_head_stable got %0d want 0", unstable); else passed++;
        instr_ready = 1'b1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                checks++; if (instr_data !== exp_d[k] || instr_addr !== 16'(k)) $display("FAIL bp_drain%0d got %h@%h want %h@%h", k, instr_data, instr_addr, exp_d[k], 16'(k)); else passed++;
                k++;
            end
            tick();
        end
        checks++; if (k !== 3) $display("FAIL bp_resume got %0d want 3", k); else passed++;
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0;
        do_reset(16'h0000);
        mem_gnt = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        redirect = 1'b1; redirect_addr = 16'h0040;
        @(negedge clk);
        checks++; if ({pc_load, pc_increment, mem_req} !== 3'b100 || pc_data !== 16'h0040) $display("FAIL rw_strobe got ld%b inc%b req%b data %h want ld1 inc0 req0 data 0040", pc_load, pc_increment, mem_req, pc_data); else passed++;
        tick();
        redirect = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hA000;
        @(negedge clk);
        checks++; if (pc_load !== 1'b0 || pc_data !== 16'h0000) $display("FAIL rw_load_pulse got ld%b data %h want ld0 data 0000", pc_load, pc_data); else passed++;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) $display("FAIL rw_stale_dropped got %b want 0", instr_valid); else passed++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL rw_new_req got %b@%h want 1@0040", mem_req, mem_addr); else passed++;
        auto_mem = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found || instr_addr !== 16'h0040 || instr_data !== 16'hA040) $display("FAIL rw_target got v%b %h@%h want v1 a040@0040", found, instr_data, instr_addr); else passed++;
    endtask

    task automatic test_redirect_edges();
        do_reset(16'h0000);
        mem_gnt = 1'b1; instr_ready = 1'b0;
        tick();
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hA000; redirect = 1'b1; redirect_addr = 16'h0080;
        @(negedge clk);
        checks++; if ({pc_load, pc_increment, mem_req} !== 3'b100) $display("FAIL rr_strobe got ld%b inc%b req%b want 100", pc_load, pc_increment, mem_req); else passed++;
        tick();
        mem_rvalid = 1'b0; redirect = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) $display("FAIL rr_no_push got %b want 0", instr_valid); else passed++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0080) $display("FAIL rr_req got %b@%h want 1@0080", mem_req, mem_addr); else passed++;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_data !== 16'h1234 || instr_addr !== 16'h0080) $display("FAIL rr_next_word got v%b %h@%h want v1 1234@0080", instr_valid, instr_data, instr_addr); else passed++;
        redirect = 1'b1; redirect_addr = 16'h0100;
        @(negedge clk);
        checks++; if ({pc_load, pc_increment, mem_req} !== 3'b100 || pc_data !== 16'h0100) $display("FAIL rq_strobe got ld%b inc%b req%b data %h want 100 0100", pc_load, pc_increment, mem_req, pc_data); else passed++;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) $display("FAIL rq_flush got %b want 0", instr_valid); else passed++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) $display("FAIL rq_req got %b@%h want 1@0100", mem_req, mem_addr); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset(16'h0000);
        mem_gnt = 1'b1; instr_ready = 1'b0; auto_mem = 1'b1;
        tick();
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) $display("FAIL ar_pre got v%b req%b want v1 req0", instr_valid, mem_req); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({pc_load, pc_increment, pc_data, mem_req, mem_addr, instr_valid, instr_data, instr_addr} !== 68'd0)
            $display("FAIL ar_outputs got ld%b inc%b pd%h req%b ma%h v%b d%h a%h want all 0", pc_load, pc_increment, pc_data, mem_req, mem_addr, instr_valid, instr_data, instr_addr); else passed++;
        auto_mem = 1'b0; pend = 1'b0; mem_rvalid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) $display("FAIL ar_idle got %b want 0", mem_req); else passed++;
        tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) $display("FAIL ar_restart got %b@%h want 1@0002", mem_req, mem_addr); else passed++;
    endtask

    task automatic test_wrap();
        do_reset(16'hFFFF);
        mem_gnt = 1'b1; instr_ready = 1'b1; auto_mem = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) $display("FAIL wrap_req got %b@%h want 1@ffff", mem_req, mem_addr); else passed++;
        tick();
        tick();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'hFFFF || instr_data !== 16'h9FFF) $display("FAIL wrap_tag got v%b %h@%h want v1 9fff@ffff", instr_valid, instr_data, instr_addr); else passed++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL wrap_next got %b@%h want 1@0000", mem_req, mem_addr); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_edges();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
